// File: rtl/sdes_key_schedule_if.sv
// Key-load handshake and subkey bundle between an S-DES key source and the
// key schedule. Signal names are written from the key schedule's point of view.
interface sdes_key_schedule_if;
  logic [9:0] i_key;
  logic       i_key_valid;
  logic       o_key_ready;
  logic [7:0] o_key1;
  logic [7:0] o_key2;
  logic       o_keys_valid;

  modport master (
    output i_key, i_key_valid,
    input  o_key_ready, o_key1, o_key2, o_keys_valid
  );

  modport slave (
    input  i_key, i_key_valid,
    output o_key_ready, o_key1, o_key2, o_keys_valid
  );
endinterface

// File: rtl/sdes_key_schedule.sv
// Sequential S-DES subkey generator: P10, then LS-1/P8 for K1 and LS-2/P8 for K2,
// one step per clock after a key is accepted. Position 1 of every table is the MSB.
module sdes_key_schedule #(
  parameter bit CLEAR_ON_LOAD = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst,
  sdes_key_schedule_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PERM   = 2'd1;
  localparam logic [1:0] S_ROUND1 = 2'd2;
  localparam logic [1:0] S_ROUND2 = 2'd3;

  logic [1:0] r_state;
  logic       r_ready;
  logic [9:0] r_key;
  logic [9:0] r_shreg;
  logic [7:0] r_key1;
  logic [7:0] r_key2;
  logic       r_keys_valid;

  logic [1:0] w_state_nxt;
  logic [9:0] w_ls1;
  logic [9:0] w_ls2;

  // P10 = 3 5 2 7 4 10 1 9 8 6; table position p maps to bit [10-p].
  function automatic logic [9:0] f_p10(input logic [9:0] k);
    f_p10 = {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // P8 = 6 3 7 4 8 5 10 9, selecting from the 10-bit rotated value.
  function automatic logic [7:0] f_p8(input logic [9:0] s);
    f_p8 = {s[4], s[7], s[3], s[6], s[2], s[5], s[0], s[1]};
  endfunction

  function automatic logic [9:0] f_ls1(input logic [9:0] s);
    f_ls1 = {s[8:5], s[9], s[3:0], s[4]};
  endfunction

  function automatic logic [9:0] f_ls2(input logic [9:0] s);
    f_ls2 = {s[7:5], s[9:8], s[2:0], s[4:3]};
  endfunction

  // Next-state decode and the two half-rotations of the working register.
  always_comb begin
    w_state_nxt = r_state;
    w_ls1       = f_ls1(r_shreg);
    w_ls2       = f_ls2(r_shreg);
    case (r_state)
      S_IDLE: begin
        if (bus.i_key_valid) begin
          w_state_nxt = S_PERM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PERM:   w_state_nxt = S_ROUND1;
      S_ROUND1: w_state_nxt = S_ROUND2;
      S_ROUND2: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Schedule registers; reset discards any partially computed subkeys.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_key        <= 10'd0;
      r_shreg      <= 10'd0;
      r_key1       <= 8'd0;
      r_key2       <= 8'd0;
      r_keys_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.i_key_valid) begin
            r_key        <= bus.i_key;
            r_keys_valid <= 1'b0;
            if (CLEAR_ON_LOAD) begin
              r_key1 <= 8'd0;
              r_key2 <= 8'd0;
            end
          end
        end
        S_PERM: begin
          r_shreg <= f_p10(r_key);
        end
        S_ROUND1: begin
          r_shreg <= w_ls1;
          r_key1  <= f_p8(w_ls1);
        end
        S_ROUND2: begin
          r_shreg      <= w_ls2;
          r_key2       <= f_p8(w_ls2);
          r_keys_valid <= 1'b1;
        end
        default: begin
          r_shreg <= r_shreg;
        end
      endcase
    end
  end

  assign bus.o_key_ready  = r_ready;
  assign bus.o_key1       = r_key1;
  assign bus.o_key2       = r_key2;
  assign bus.o_keys_valid = r_keys_valid;

endmodule

// File: doc/sdes_key_schedule.md
Name: sdes_key_schedule

Overview:
- Sequential S-DES key generator. Takes a 10-bit master key and produces the two 8-bit round subkeys K1 and K2.
- Sits directly upstream of the combinational S-DES encryption/decryption datapaths and drives their i_key1/i_key2 inputs.
- Computes P10, LS-1, P8, LS-2 and P8 over three cycles after a valid/ready handshake.
- Holds the resulting subkeys stable until the next key is accepted.

Parameters:
- CLEAR_ON_LOAD, 1, when 1 o_key1/o_key2 are zeroed on key acceptance; when 0 they hold their old values until overwritten.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  synchronous, active-high reset.
- i_key  input  10  master key; bit 9 is position 1 of the S-DES tables.
- i_key_valid  input  1  i_key is valid this cycle.
- o_key_ready  output  1  block can accept a key (state IDLE).
- o_key1  output  8  subkey K1; bit 7 is position 1.
- o_key2  output  8  subkey K2.
- o_keys_valid  output  1  o_key1/o_key2 hold the subkeys of the last accepted key.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on i_rst.
- Reset values:
  - state = IDLE, o_key_ready = 1, o_keys_valid = 0.
  - o_key1 = o_key2 = 0; internal key and shift registers = 0.
- Tables use 1-based positions, position 1 = MSB:
  - P10 = 3 5 2 7 4 10 1 9 8 6.
  - P8 = 6 3 7 4 8 5 10 9 (selects from the 10-bit shifted value).
  - LS-n rotates each 5-bit half left by n independently.
- States:
  - IDLE: o_key_ready = 1. On i_key_valid, at edge N: key_reg <= i_key, o_keys_valid <= 0, keys cleared if CLEAR_ON_LOAD, next state PERM.
  - PERM: at edge N+1, shreg <= P10(key_reg); next state ROUND1.
  - ROUND1: at edge N+2, shreg <= LS1(shreg), o_key1 <= P8(LS1(shreg)); next state ROUND2.
  - ROUND2: at edge N+3, shreg <= LS2(shreg), o_key2 <= P8(LS2(shreg)), o_keys_valid <= 1; next state IDLE.
- Latency: o_keys_valid is high in the cycle after edge N+3, i.e. 3 cycles after the acceptance edge.
- Throughput: minimum one key per 4 cycles. A new handshake is possible in the first cycle o_keys_valid is high.
- i_key_valid while o_key_ready = 0: ignored, no queuing; i_key is not sampled.
- i_key changing after acceptance has no effect (key_reg is captured).
- Keys and o_keys_valid hold indefinitely in IDLE with no new handshake.
- i_rst at any state, including mid-schedule: next edge applies reset values. The partial schedule is discarded and no valid keys are produced.
- i_rst together with i_key_valid: reset wins; the key is not accepted.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: assert i_rst 2 cycles with i_key_valid = 1 -> o_key_ready = 1, o_keys_valid = 0, o_key1 = o_key2 = 0x00, and no key accepted.
- Stallings vector: i_key = 10'b1010000010 pulsed in IDLE -> 3 cycles later o_keys_valid = 1, o_key1 = 8'b10100100 (0xA4), o_key2 = 8'b01000011 (0x43). Outputs held 10+ idle cycles.
- Edge keys: 10'h000 -> K1 = K2 = 0x00; 10'h3FF -> K1 = K2 = 0xFF. With CLEAR_ON_LOAD = 1, keys read 0x00 and o_keys_valid = 0 during PERM/ROUND1.
- Busy and back-to-back:
  - Hold i_key_valid high with 0x282 then 0x3FF -> 0x3FF is not sampled while o_key_ready = 0.
  - Second acceptance occurs the cycle o_keys_valid first rises; 0xFF/0xFF appears 3 cycles later.
  - Changing i_key during PERM/ROUND1 does not alter results.
- Mid-operation reset: accept 0x282, assert i_rst in ROUND1 -> o_keys_valid stays 0, keys = 0x00, state IDLE. A subsequent 0x282 gives 0xA4/0x43.
- Integration: drive this block's outputs into the decryption datapath, key 0x282, ciphertext 8'b00111000 -> o_plaintext = 8'b10010111 once o_keys_valid = 1.
